// File: rtl/cabin_pkg.sv
// Shared types, defaults and helpers for the cabin attendant-call controller.
package cabin_pkg;

  // Serving FSM: idle, presenting a seat, presenting with escalation raised.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESENT   = 2'd1,
    ESCALATED = 2'd2
  } state_t;

  localparam int DEF_NUM_SEATS  = 8;
  localparam int DEF_ESC_CYCLES = 1000;

  // Number of set bits; callers zero-extend their vector to 64 bits.
  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c = c + int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_seat_picker.sv
// Combinational round-robin search: first lit seat at or above the pointer,
// wrapping past the top seat back to seat 0.
module rr_seat_picker
  import cabin_pkg::*;
#(
  parameter  int NUM_SEATS = DEF_NUM_SEATS,
  localparam int SEAT_W    = $clog2(NUM_SEATS)
) (
  input  logic [NUM_SEATS-1:0] i_lights,
  input  logic [SEAT_W-1:0]    i_ptr,
  output logic                 o_found,
  output logic [SEAT_W-1:0]    o_idx
);

  // Walk offsets from the farthest down to zero so the nearest lit seat wins.
  always_comb begin
    int                j;
    logic [SEAT_W-1:0] w_j;
    o_found = 1'b0;
    o_idx   = '0;
    j       = 0;
    w_j     = '0;
    for (int k = NUM_SEATS - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= NUM_SEATS) begin
        j = j - NUM_SEATS;
      end
      w_j = SEAT_W'(j);
      if (i_lights[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/cabin_call_controller.sv
// Multi-seat attendant-call controller: per-seat latched call lights, a
// round-robin presenter waiting for acknowledge, escalation on timeout and a
// registered count of lit seats.
module cabin_call_controller
  import cabin_pkg::*;
#(
  parameter  int NUM_SEATS  = DEF_NUM_SEATS,
  parameter  int ESC_CYCLES = DEF_ESC_CYCLES,
  localparam int SEAT_W     = $clog2(NUM_SEATS),
  localparam int CNT_W      = $clog2(ESC_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SEATS-1:0] call_button,
  input  logic [NUM_SEATS-1:0] cancel_button,
  input  logic                 ack,
  output logic [NUM_SEATS-1:0] light_state,
  output logic                 serve_valid,
  output logic [SEAT_W-1:0]    serve_seat,
  output logic                 escalate,
  output logic [SEAT_W:0]      pending_count
);

  state_t               r_state, w_state_nxt;
  logic [NUM_SEATS-1:0] r_light, w_light_nxt;
  logic [SEAT_W-1:0]    r_seat, w_seat_nxt;
  logic [SEAT_W-1:0]    r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]     r_timer, w_timer_nxt;
  logic [SEAT_W:0]      r_pend;
  logic                 w_serving;
  logic                 w_ack_clr;
  logic                 w_found;
  logic [SEAT_W-1:0]    w_pick;

  assign w_serving = (r_state != IDLE);
  // ack only means something while a seat is actually on the panel.
  assign w_ack_clr = ack & w_serving;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEATS; gi++) begin : g_seat
      // A fresh call beats an ack clear; otherwise ack or cancel clears, 11 holds.
      assign w_light_nxt[gi] =
        (call_button[gi] & ~cancel_button[gi])            ? 1'b1 :
        (w_ack_clr && (r_seat == SEAT_W'(gi)))             ? 1'b0 :
        (~call_button[gi] & cancel_button[gi])            ? 1'b0 :
                                                            r_light[gi];

      // Per-seat call light register.
      always_ff @(posedge clk) begin
        if (reset) r_light[gi] <= 1'b0;
        else       r_light[gi] <= w_light_nxt[gi];
      end
    end
  endgenerate

  rr_seat_picker #(.NUM_SEATS(NUM_SEATS)) u_picker (
    .i_lights (r_light),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_idx    (w_pick)
  );

  // Serving FSM next state: ack beats cancel-drop beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_seat_nxt  = r_seat;
    w_ptr_nxt   = r_ptr;
    w_timer_nxt = r_timer;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_seat_nxt  = w_pick;
          w_timer_nxt = '0;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT, ESCALATED: begin
        if (r_state == PRESENT) begin
          w_timer_nxt = r_timer + CNT_W'(1);
        end
        if (ack) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = (r_seat == SEAT_W'(NUM_SEATS - 1)) ? '0 : r_seat + SEAT_W'(1);
        end else if (!w_light_nxt[r_seat]) begin
          w_state_nxt = IDLE;
        end else if ((r_state == PRESENT) && (r_timer == CNT_W'(ESC_CYCLES - 1))) begin
          w_state_nxt = ESCALATED;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control and count registers; pending count follows next-state lights.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_seat  <= '0;
      r_ptr   <= '0;
      r_timer <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_seat  <= w_seat_nxt;
      r_ptr   <= w_ptr_nxt;
      r_timer <= w_timer_nxt;
      r_pend  <= (SEAT_W + 1)'(popcount(64'(w_light_nxt)));
    end
  end

  assign light_state   = r_light;
  assign serve_valid   = w_serving;
  assign serve_seat    = r_seat;
  assign escalate      = (r_state == ESCALATED);
  assign pending_count = r_pend;

endmodule

// File: tb/tb_cabin_call_controller.sv
// Self-checking bench for cabin_call_controller (8 seats, escalation after 10).
module tb_cabin_call_controller;

  localparam int N   = 8;
  localparam int ESC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] call_button;
  logic [N-1:0] cancel_button;
  logic         ack;
  logic [N-1:0] light_state;
  logic         serve_valid;
  logic [2:0]   serve_seat;
  logic         escalate;
  logic [3:0]   pending_count;

  cabin_call_controller #(.NUM_SEATS(N), .ESC_CYCLES(ESC)) dut (
    .clk           (clk),
    .reset         (reset),
    .call_button   (call_button),
    .cancel_button (cancel_button),
    .ack           (ack),
    .light_state   (light_state),
    .serve_valid   (serve_valid),
    .serve_seat    (serve_seat),
    .escalate      (escalate),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] call;
    logic [7:0] cancel;
    logic       ack;
    logic [7:0] light;
    logic [3:0] pend;
    logic       sv;
    logic [2:0] seat;
    logic       esc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_step  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", n_step, name, act, exp);
  endtask

  function automatic vec_t mk(input logic rst, input logic [7:0] call, input logic [7:0] cancel,
                              input logic a, input logic [7:0] light, input logic [3:0] pend,
                              input logic sv, input logic [2:0] seat, input logic esc);
    vec_t v;
    v.rst = rst; v.call = call; v.cancel = cancel; v.ack = a;
    v.light = light; v.pend = pend; v.sv = sv; v.seat = seat; v.esc = esc;
    return v;
  endfunction

  task automatic add(input logic rst, input logic [7:0] call, input logic [7:0] cancel,
                     input logic a, input logic [7:0] light, input logic [3:0] pend,
                     input logic sv, input logic [2:0] seat, input logic esc);
    tbl.push_back(mk(rst, call, cancel, a, light, pend, sv, seat, esc));
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    reset         = v.rst;
    call_button   = v.call;
    cancel_button = v.cancel;
    ack           = v.ack;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    n_step++;
    e = exp_q.pop_front();
    chk("light_state",   int'(light_state),   int'(e.light));
    chk("pending_count", int'(pending_count), int'(e.pend));
    chk("serve_valid",   int'(serve_valid),   int'(e.sv));
    chk("escalate",      int'(escalate),      int'(e.esc));
    if (e.sv) chk("serve_seat", int'(serve_seat), int'(e.seat));
  endtask

  task automatic s(input logic rst, input logic [7:0] call, input logic [7:0] cancel,
                   input logic a, input logic [7:0] light, input logic [3:0] pend,
                   input logic sv, input logic [2:0] seat, input logic esc);
    step(mk(rst, call, cancel, a, light, pend, sv, seat, esc));
  endtask

  initial begin
    reset = 1'b1; call_button = '0; cancel_button = '0; ack = 1'b0;
    #2;

    // Reset with all calls held, then release.
    add(1, 8'hFF, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hFF, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'hFF, 8'h00, 0, 8'hFF, 8, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'hFF, 8, 1, 0, 0);
    add(0, 8'h00, 8'h00, 1, 8'hFE, 7, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'hFE, 7, 1, 1, 0);
    // Round-robin 1,5,6 then wrap to relit seat 1.
    add(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h62, 8'h00, 0, 8'h62, 3, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h62, 3, 1, 1, 0);
    add(0, 8'h00, 8'h00, 1, 8'h60, 2, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h60, 2, 1, 5, 0);
    add(0, 8'h00, 8'h00, 1, 8'h40, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h40, 1, 1, 6, 0);
    add(0, 8'h02, 8'h00, 0, 8'h42, 2, 1, 6, 0);
    add(0, 8'h00, 8'h00, 1, 8'h02, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h02, 1, 1, 1, 0);
    add(0, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    // Cancel of presented seat 2, seat 4 served next.
    add(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h14, 8'h00, 0, 8'h14, 2, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h14, 2, 1, 2, 0);
    add(0, 8'h00, 8'h04, 0, 8'h10, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h10, 1, 1, 4, 0);
    add(0, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    // Cancel leaves pointer at 0: relit seat 1 is chosen over seat 4.
    add(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h14, 8'h00, 0, 8'h14, 2, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h14, 2, 1, 2, 0);
    add(0, 8'h02, 8'h04, 0, 8'h12, 2, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h12, 2, 1, 1, 0);
    add(0, 8'h00, 8'h00, 1, 8'h10, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h10, 1, 1, 4, 0);
    add(0, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    // Ack on seat 2 with a fresh seat-2 call: light stays, pointer moves to 3.
    add(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h04, 8'h00, 0, 8'h04, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h04, 1, 1, 2, 0);
    add(0, 8'h05, 8'h00, 1, 8'h05, 2, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h05, 2, 1, 0, 0);
    add(0, 8'h00, 8'h00, 1, 8'h04, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h04, 1, 1, 2, 0);
    add(0, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    // Seat 0 truth table with light 0 and 1; ack in IDLE is ignored.
    add(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 8'h01, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h01, 8'h01, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h01, 8'h00, 1, 8'h01, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 1, 8'h01, 1, 1, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h01, 1, 1, 0, 0);
    add(0, 8'h01, 8'h01, 0, 8'h01, 1, 1, 0, 0);
    add(0, 8'h00, 8'h01, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h01, 8'h00, 0, 8'h01, 1, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h01, 1, 1, 0, 0);
    add(0, 8'h01, 8'h00, 0, 8'h01, 1, 1, 0, 0);
    add(0, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Escalation: seat 3 pulse, serve at edge 2, escalate at edge 12.
    s(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    s(0, 8'h08, 8'h00, 0, 8'h08, 1, 0, 0, 0);
    s(0, 8'h00, 8'h00, 0, 8'h08, 1, 1, 3, 0);
    for (int k = 0; k < ESC - 1; k++) s(0, 8'h00, 8'h00, 0, 8'h08, 1, 1, 3, 0);
    s(0, 8'h00, 8'h00, 0, 8'h08, 1, 1, 3, 1);
    // Another seat calls while escalated: no preemption, escalation holds.
    s(0, 8'h01, 8'h00, 0, 8'h09, 2, 1, 3, 1);
    s(0, 8'h00, 8'h00, 1, 8'h01, 1, 0, 0, 0);
    s(0, 8'h00, 8'h00, 0, 8'h01, 1, 1, 0, 0);
    // Reset mid-presentation with buttons held: everything cleared, buttons ignored.
    s(1, 8'hFF, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    s(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    s(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
